perceptron_bp_trainer: RTL

// - Parametrised global-history perceptron branch predictor. It predicts at fetch and trains at execute.
// - Adds three things over the previous generation:
//   - speculative GHR with misprediction recovery
//   - threshold-gated training through a valid/ready FSM
//   - saturating signed weights
// - Sits beside the fetch stage. GHR_F travels down the pipe with the branch and returns as GHR_EX.

---
 rtl/perceptron_bp_trainer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/perceptron_bp_trainer.sv
// rtl/perceptron_bp_trainer.sv - global-history perceptron predictor with speculative GHR and threshold-gated trainer
// Optional counters: define PERCEPTRON_STATS_EN to add stat_mispredict/stat_train.
module perceptron_bp_trainer #(
  parameter int H       = 12,
  parameter int N       = 256,
  parameter int W_WIDTH = 8,
  parameter int PC_BITS = 12,
  parameter int THETA   = 37
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PERCEPTRON_STATS_EN
  output logic [31:0]        stat_mispredict,
  output logic [31:0]        stat_train,
`endif
  input  logic [PC_BITS-1:0] PC_F,
  input  logic               branch_en_F,
  output logic               BP_valid,
  output logic               BP_decision,
  output logic [H-1:0]       GHR_F,
  input  logic               branch_en_EX,
  output logic               train_ready,
  input  logic [PC_BITS-1:0] PC_EX,
  input  logic [H-1:0]       GHR_EX,
  input  logic               branch_result,
  input  logic               branch_correction
);

  localparam int IDX  = $clog2(N);
  localparam int ROWW = (H + 1) * W_WIDTH;
  localparam int YW   = W_WIDTH + $clog2(H + 1) + 1;

  localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};
  localparam logic signed [W_WIDTH-1:0] W_ONE = {{(W_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [YW-1:0]      THETA_Y = YW'(THETA);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE} state_t;

  // Both operands are zero-extended so short histories or PCs still form a full index.
  function automatic logic [IDX-1:0] f_idx(input logic [PC_BITS-1:0] pc, input logic [H-1:0] hist);
    logic [IDX+H-1:0]       h_ext;
    logic [IDX+PC_BITS-1:0] p_ext;
    h_ext = {{IDX{1'b0}}, hist};
    p_ext = {{IDX{1'b0}}, pc};
    return p_ext[IDX-1:0] ^ h_ext[IDX-1:0];
  endfunction

  function automatic logic signed [YW-1:0] f_sx(input logic signed [W_WIDTH-1:0] w);
    return {{(YW-W_WIDTH){w[W_WIDTH-1]}}, w};
  endfunction

  function automatic logic signed [YW-1:0] f_dot(input logic [ROWW-1:0] row, input logic [H-1:0] hist);
    logic signed [YW-1:0] acc;
    logic signed [YW-1:0] term;
    acc = f_sx(row[W_WIDTH-1:0]);
    for (int i = 1; i <= H; i++) begin
      term = f_sx(row[i*W_WIDTH +: W_WIDTH]);
      acc  = hist[i-1] ? (acc + term) : (acc - term);
    end
    return acc;
  endfunction

  function automatic logic signed [W_WIDTH-1:0] f_sat(input logic signed [W_WIDTH-1:0] w, input logic up);
    if (up) return (w == W_MAX) ? w : (w + W_ONE);
    else    return (w == W_MIN) ? w : (w - W_ONE);
  endfunction

  function automatic logic [ROWW-1:0] f_upd(input logic [ROWW-1:0] row, input logic [H-1:0] hist, input logic res);
    logic [ROWW-1:0] nrow;
    nrow[W_WIDTH-1:0] = f_sat(row[W_WIDTH-1:0], res);
    for (int i = 1; i <= H; i++)
      nrow[i*W_WIDTH +: W_WIDTH] = f_sat(row[i*W_WIDTH +: W_WIDTH], res == hist[i-1]);
    return nrow;
  endfunction

  logic [ROWW-1:0] r_tab [N];
  logic [H-1:0]    r_ghr;
  logic [H-1:0]    r_ghr_f;
  logic [H-1:0]    r_ghr_ex;
  logic [IDX-1:0]  r_tidx;
  logic            r_bp_valid;
  logic            r_bp_dec;
  logic            r_ready;
  logic            r_res;
  logic            r_corr;
  state_t          r_state;

  logic [IDX-1:0]       w_pidx;
  logic signed [YW-1:0] w_py;
  logic                 w_pdec;
  logic signed [YW-1:0] w_ty;
  logic signed [YW-1:0] w_tabs;
  logic                 w_train;
  logic [ROWW-1:0]      w_new_row;
  logic                 w_accept;
  logic                 w_unused;

  assign w_pidx    = f_idx(PC_F, r_ghr);
  assign w_py      = f_dot(r_tab[w_pidx], r_ghr);
  assign w_pdec    = ~w_py[YW-1];
  assign w_ty      = f_dot(r_tab[r_tidx], r_ghr_ex);
  assign w_tabs    = w_ty[YW-1] ? -w_ty : w_ty;
  assign w_train   = r_corr | (w_tabs <= THETA_Y);
  assign w_new_row = f_upd(r_tab[r_tidx], r_ghr_ex, r_res);
  assign w_accept  = branch_en_EX & r_ready;
  assign w_unused  = ^{PC_F, PC_EX};

`ifdef PERCEPTRON_STATS_EN
  logic [31:0] r_stat_mis;
  logic [31:0] r_stat_train;
  assign stat_mispredict = r_stat_mis;
  assign stat_train      = r_stat_train;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) r_tab[r] <= '0;
      r_ghr      <= '0;
      r_ghr_f    <= '0;
      r_ghr_ex   <= '0;
      r_tidx     <= '0;
      r_bp_valid <= 1'b0;
      r_bp_dec   <= 1'b0;
      r_ready    <= 1'b1;
      r_res      <= 1'b0;
      r_corr     <= 1'b0;
      r_state    <= S_IDLE;
`ifdef PERCEPTRON_STATS_EN
      r_stat_mis   <= '0;
      r_stat_train <= '0;
`endif
    end else begin
      r_bp_valid <= branch_en_F;
      if (branch_en_F) begin
        r_bp_dec <= w_pdec;
        r_ghr_f  <= r_ghr;
        r_ghr    <= {r_ghr[H-2:0], w_pdec};
      end
      // Recovery comes later in the block so it wins over a same-cycle speculative shift.
      if (w_accept && branch_correction) begin
        r_ghr <= {GHR_EX[H-2:0], branch_result};
`ifdef PERCEPTRON_STATS_EN
        r_stat_mis <= r_stat_mis + 32'd1;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tidx   <= f_idx(PC_EX, GHR_EX);
            r_ghr_ex <= GHR_EX;
            r_res    <= branch_result;
            r_corr   <= branch_correction;
            r_ready  <= 1'b0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_train) begin
            r_state <= S_WRITE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WRITE: begin
          r_tab[r_tidx] <= w_new_row;
          r_ready       <= 1'b1;
          r_state       <= S_IDLE;
`ifdef PERCEPTRON_STATS_EN
          r_stat_train <= r_stat_train + 32'd1;
`endif
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BP_valid    = r_bp_valid;
  assign BP_decision = r_bp_dec;
  assign GHR_F       = r_ghr_f;
  assign train_ready = r_ready;

endmodule
